md_sched: RTL and testbench

- Multiply/divide scheduler for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO registers.
- Models fixed multi-cycle latency by latching operands, computing the result and counting down before committing to HI/LO.
- Raises a stall request to the hazard logic while a D-stage instruction needs the unit and the unit is busy.

---
 rtl/md_sched_pkg.sv | 29 ++
 rtl/md_sched_if.sv | 23 ++
 rtl/md_compute.sv | 63 ++++++
 rtl/md_sched.sv | 134 +++++++++++++
 tb/tb_md_sched.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings,
// default latencies and FSM state encodings.
package md_sched_pkg;

   typedef enum logic [2:0] {
      MD_NOP   = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MUL_LAT_DEF = 5;
   localparam int DIV_LAT_DEF = 10;

   // Ops that occupy the unit for multiple cycles.
   function automatic logic is_muldiv(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_sched_if.sv
// Handshake/bus bundle between the E/D pipeline stages and md_sched.
interface md_sched_if;
   logic        md_valid_E;
   logic [2:0]  md_op_E;
   logic [31:0] rs_E;
   logic [31:0] rt_E;
   logic        md_use_D;
   logic        stall_D;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output md_valid_E, md_op_E, rs_E, rt_E, md_use_D,
      input  stall_D, busy, done, hi, lo
   );

   modport slave (
      input  md_valid_E, md_op_E, rs_E, rt_E, md_use_D,
      output stall_D, busy, done, hi, lo
   );
endinterface

// File: rtl/md_compute.sv
// Combinational HI/LO result for a latched mult/div op, including the
// divide-by-zero (keep HI/LO) and INT_MIN / -1 overflow rules.
module md_compute
   import md_sched_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi_cur,
   input  logic [31:0] lo_cur,
   output logic [31:0] hi_n,
   output logic [31:0] lo_n
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic               div_zero;
   logic               div_ovf;

   always_comb begin
      a_s      = $signed(a);
      b_s      = $signed(b);
      prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u   = {32'd0, a} * {32'd0, b};
      div_zero = (b == 32'd0);
      // INT_MIN / -1 cannot be represented; MIPS leaves quotient = INT_MIN.
      div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      quo_s    = '0;
      rem_s    = '0;
      if (div_ovf) begin
         quo_s = a_s;
         rem_s = '0;
      end else if (!div_zero) begin
         quo_s = a_s / b_s;
         rem_s = a_s % b_s;
      end

      hi_n = hi_cur;
      lo_n = lo_cur;
      case (op)
         MD_MULT:  {hi_n, lo_n} = prod_s;
         MD_MULTU: {hi_n, lo_n} = prod_u;
         MD_DIV: begin
            if (!div_zero) begin
               lo_n = quo_s;
               hi_n = rem_s;
            end
         end
         MD_DIVU: begin
            if (!div_zero) begin
               lo_n = a / b;
               hi_n = a % b;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler owning HI/LO with fixed-latency commit.
// Optional exception flush input enabled by MD_SCHED_CANCEL_EN.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
)
(
   input  logic           clk,
   input  logic           rst_n,
`ifdef MD_SCHED_CANCEL_EN
   input  logic           md_cancel,
`endif
   md_sched_if.slave      md
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   md_op_e             op_q, op_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [31:0]        hi_n, lo_n;
   logic               cancel;
   md_op_e             op_in;

`ifdef MD_SCHED_CANCEL_EN
   assign cancel = md_cancel;
`else
   assign cancel = 1'b0;
`endif

   assign op_in = md_op_e'(md.md_op_E);

   md_compute u_compute (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi_cur (hi_q),
      .lo_cur (lo_q),
      .hi_n   (hi_n),
      .lo_n   (lo_n)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (md.md_valid_E && !cancel) begin
               case (op_in)
                  MD_MULT, MD_MULTU: begin
                     op_d    = op_in;
                     a_d     = md.rs_E;
                     b_d     = md.rt_E;
                     cnt_d   = CNT_W'(MUL_LAT - 1);
                     state_d = ST_RUN;
                  end
                  MD_DIV, MD_DIVU: begin
                     op_d    = op_in;
                     a_d     = md.rs_E;
                     b_d     = md.rt_E;
                     cnt_d   = CNT_W'(DIV_LAT - 1);
                     state_d = ST_RUN;
                  end
                  MD_MTHI: hi_d = md.rs_E;
                  MD_MTLO: lo_d = md.rs_E;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Flush wins over a same-cycle commit.
            if (cancel) begin
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               hi_d    = hi_n;
               lo_d    = lo_n;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Operand latches are only consumed in RUN, so they need no reset.
   always_ff @(posedge clk) begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
   end

   assign md.stall_D = md.md_use_D & (busy_q | (md.md_valid_E & is_muldiv(md.md_op_E)));
   assign md.busy    = busy_q;
   assign md.done    = done_q;
   assign md.hi      = hi_q;
   assign md.lo      = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched (default latencies 5/10).
module tb_md_sched;
   import md_sched_pkg::*;

   logic clk;
   logic rst_n;
`ifdef MD_SCHED_CANCEL_EN
   logic md_cancel;
`endif
   int   n_assert;
   int   n_fail;

   md_sched_if mif ();

   md_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MD_SCHED_CANCEL_EN
      .md_cancel (md_cancel),
`endif
      .md        (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      mif.md_valid_E = 1'b1;
      mif.md_op_E    = op;
      mif.rs_E       = a;
      mif.rt_E       = b;
      tick();
      mif.md_valid_E = 1'b0;
      mif.md_op_E    = 3'd0;
      mif.rs_E       = 32'hA5A5_A5A5;
      mif.rt_E       = 32'h5A5A_5A5A;
   endtask

   // Issue, then count busy/done cycles over a bounded window and check the commit.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int busy_cyc;
      int done_cyc;
      busy_cyc = 0;
      done_cyc = 0;
      issue(op, a, b);
      for (int i = 0; i < lat + 3; i++) begin
         if (mif.busy) busy_cyc++;
         if (mif.done) done_cyc++;
         tick();
      end
      chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(lat));
      chk({tag, "_done_pulses"}, 32'(done_cyc), 32'd1);
      chk({tag, "_hi"}, mif.hi, exp_hi);
      chk({tag, "_lo"}, mif.lo, exp_lo);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         assert (!(mif.busy && mif.md_valid_E && (mif.md_op_E inside {[3'd1:3'd6]}))) else begin
            n_fail++;
            $error("FAIL protocol: md op 0x%0h in E while busy", mif.md_op_E);
         end
      end
   end

   initial begin
      int done_cyc;
      n_assert = 0;
      n_fail   = 0;
      rst_n          = 1'b0;
      mif.md_valid_E = 1'b0;
      mif.md_op_E    = 3'd0;
      mif.rs_E       = '0;
      mif.rt_E       = '0;
      mif.md_use_D   = 1'b0;
`ifdef MD_SCHED_CANCEL_EN
      md_cancel      = 1'b0;
`endif
      tick();
      tick();
      chk("rst_hi",    mif.hi, 32'd0);
      chk("rst_lo",    mif.lo, 32'd0);
      chk("rst_busy",  32'(mif.busy), 32'd0);
      chk("rst_done",  32'(mif.done), 32'd0);
      chk("rst_stall", 32'(mif.stall_D), 32'd0);
      rst_n = 1'b1;
      tick();

      run_op("mult_neg",  3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu",     3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("div_neg",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu",      3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
      run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 32'd2, 32'd14);
      run_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

      issue(3'd5, 32'h1234_5678, 32'd0);
      chk("mthi_hi",   mif.hi, 32'h1234_5678);
      chk("mthi_busy", 32'(mif.busy), 32'd0);
      chk("mthi_done", 32'(mif.done), 32'd0);
      issue(3'd6, 32'h9ABC_DEF0, 32'd0);
      chk("mtlo_lo",   mif.lo, 32'h9ABC_DEF0);
      chk("mtlo_hi",   mif.hi, 32'h1234_5678);
      chk("mtlo_done", 32'(mif.done), 32'd0);

      // MFLO waiting in D across a whole MULT.
      mif.md_use_D   = 1'b1;
      mif.md_valid_E = 1'b1;
      mif.md_op_E    = 3'd1;
      mif.rs_E       = 32'd4;
      mif.rt_E       = 32'd5;
      #1;
      chk("stall_issue", 32'(mif.stall_D), 32'd1);
      tick();
      mif.md_valid_E = 1'b0;
      mif.md_op_E    = 3'd0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_run%0d", i), 32'(mif.stall_D), 32'd1);
         tick();
      end
      chk("stall_after", 32'(mif.stall_D), 32'd0);
      chk("stall_done",  32'(mif.done), 32'd1);
      chk("stall_lo",    mif.lo, 32'd20);
      mif.md_use_D = 1'b0;
      tick();

      // Async reset in the middle of a DIV (cnt = 4).
      issue(3'd3, 32'd100, 32'd3);
      for (int i = 0; i < 5; i++) tick();
      chk("mid_busy_pre", 32'(mif.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_hi",   mif.hi, 32'd0);
      chk("mid_rst_lo",   mif.lo, 32'd0);
      chk("mid_rst_busy", 32'(mif.busy), 32'd0);
      #2;
      rst_n = 1'b1;
      done_cyc = 0;
      for (int i = 0; i < 12; i++) begin
         if (mif.done) done_cyc++;
         tick();
      end
      chk("mid_rst_no_done", 32'(done_cyc), 32'd0);
      run_op("mult_after_rst", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);

`ifdef MD_SCHED_CANCEL_EN
      issue(3'd1, 32'd2, 32'd3);
      for (int i = 0; i < 4; i++) tick();
      chk("cancel_busy_pre", 32'(mif.busy), 32'd1);
      md_cancel = 1'b1;
      tick();
      md_cancel = 1'b0;
      chk("cancel_busy", 32'(mif.busy), 32'd0);
      chk("cancel_done", 32'(mif.done), 32'd0);
      chk("cancel_lo",   mif.lo, 32'd42);
      tick();
      chk("cancel_done_late", 32'(mif.done), 32'd0);
      chk("cancel_hi",        mif.hi, 32'd0);
      md_cancel = 1'b1;
      issue(3'd5, 32'hDEAD_BEEF, 32'd0);
      chk("cancel_mthi_hi", mif.hi, 32'd0);
      md_cancel = 1'b1;
      issue(3'd1, 32'd2, 32'd3);
      md_cancel = 1'b0;
      chk("cancel_issue_busy", 32'(mif.busy), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
